// File: rtl/multi_note_sequencer.sv
// Multi-note sequencer: queues (note, duration) requests in a FIFO and plays them
// back-to-back through one square-wave tone generator that restarts its phase per note.
module multi_note_sequencer #(
    parameter int NUM_NOTES = 7,
    parameter int SEL_W     = 3,
    parameter int PERIOD_W  = 8,
    parameter int DUR_W     = 16,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_NOTES*PERIOD_W-1:0] note_periods,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic [SEL_W-1:0]              req_num,
    input  logic [DUR_W-1:0]              req_dur,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          busy,
    output logic [SEL_W-1:0]              note_sel,
    output logic                          note
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [SEL_W-1:0] num;
        logic [DUR_W-1:0] dur;
    } req_t;

    typedef enum logic {IDLE, PLAY} state_t;

    req_t                mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                push;
    logic                pop;
    req_t                head;
    state_t              state;
    state_t              state_nxt;
    logic [DUR_W-1:0]    dur_cnt;
    logic [PERIOD_W-1:0] tone_cnt;
    logic [PERIOD_W-1:0] cur_period;
    logic [PERIOD_W-1:0] head_period;

    // Half-period lookup; note 0 and any number above NUM_NOTES resolve to 0 (silent).
    function automatic logic [PERIOD_W-1:0] period_of(
        input logic [SEL_W-1:0]              num,
        input logic [NUM_NOTES*PERIOD_W-1:0] periods
    );
        logic [PERIOD_W-1:0] p;
        p = '0;
        for (int i = 1; i <= NUM_NOTES; i++) begin
            if (num == SEL_W'(i)) p = periods[(i-1)*PERIOD_W +: PERIOD_W];
        end
        return p;
    endfunction

    assign req_rdy     = (occupancy != OCC_W'(DEPTH));
    assign push        = req_val && req_rdy;
    assign head        = mem[rd_ptr];
    assign busy        = (state == PLAY);
    assign cur_period  = period_of(note_sel, note_periods);
    assign head_period = period_of(head.num, note_periods);

    // NOTE: the storage array has no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_num, req_dur};
    end

    // Arithmetic updates (rather than if-guards) let an X on req_val reach the FIFO state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PTR_W'(push);
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (occupancy != '0) begin
                    pop       = 1'b1;
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (dur_cnt == DUR_W'(1)) begin
                    if (occupancy != '0) pop = 1'b1;
                    else                 state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            note_sel <= '0;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            note     <= 1'b0;
        end else if (pop) begin
            note_sel <= head.num;
            dur_cnt  <= (head.dur == '0) ? DUR_W'(1) : head.dur;
            tone_cnt <= '0;
            note     <= (head_period != '0);
        end else if (state == PLAY) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
            if (state_nxt == IDLE) begin
                note_sel <= '0;
                note     <= 1'b0;
                tone_cnt <= '0;
            end else if (cur_period == '0) begin
                note     <= 1'b0;
                tone_cnt <= '0;
            end else if (tone_cnt >= cur_period - PERIOD_W'(1)) begin
                // >= keeps a mid-note shrink of the period from running the counter round.
                note     <= ~note;
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multi_note_sequencer.sv
// Directed self-checking bench for multi_note_sequencer: reset, single note, back-to-back,
// FIFO full behaviour, duration/period edge cases, pointer wrap and mid-note reset.
module tb_multi_note_sequencer;

    localparam int NUM_NOTES = 7;
    localparam int SEL_W     = 3;
    localparam int PERIOD_W  = 8;
    localparam int DUR_W     = 16;
    localparam int DEPTH     = 4;
    localparam int OCC_W     = $clog2(DEPTH) + 1;

    localparam logic [NUM_NOTES*PERIOD_W-1:0] PERIODS_STD =
        {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [NUM_NOTES*PERIOD_W-1:0] PERIODS_N7_ZERO =
        {8'd0, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    logic                          clk;
    logic                          rst;
    logic [NUM_NOTES*PERIOD_W-1:0] note_periods;
    logic                          req_val;
    logic                          req_rdy;
    logic [SEL_W-1:0]              req_num;
    logic [DUR_W-1:0]              req_dur;
    logic [OCC_W-1:0]              occupancy;
    logic                          busy;
    logic [SEL_W-1:0]              note_sel;
    logic                          note;

    int checks;
    int errors;

    multi_note_sequencer #(
        .NUM_NOTES(NUM_NOTES), .SEL_W(SEL_W), .PERIOD_W(PERIOD_W),
        .DUR_W(DUR_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .note_periods(note_periods),
        .req_val(req_val), .req_rdy(req_rdy), .req_num(req_num), .req_dur(req_dur),
        .occupancy(occupancy), .busy(busy), .note_sel(note_sel), .note(note)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, note_sel, note} packed for compact per-cycle comparisons
    function automatic logic [SEL_W+1:0] play_vec();
        return {busy, note_sel, note};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_rdy, busy, note_sel, note, occupancy} !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset: rdy=%b busy=%b sel=%0d note=%b occ=%0d, want 1 0 0 0 0",
                     req_rdy, busy, note_sel, note, occupancy);
        end
    endtask

    task automatic test_single();
        logic [3:0] pat;
        pat = 4'b1100;
        req_val = 1'b1; req_num = 3'd2; req_dur = 16'd4;
        tick();
        req_val = 1'b0;
        checks++;
        if ({occupancy, busy} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_accept: occ=%0d busy=%b, want 1 0", occupancy, busy);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (play_vec() !== {1'b1, 3'd2, pat[3-i]}) begin
                errors++;
                $display("FAIL single_cycle%0d: {busy,sel,note}=%b, want %b",
                         i, play_vec(), {1'b1, 3'd2, pat[3-i]});
            end
            tick();
        end
        checks++;
        if ({play_vec(), occupancy} !== {1'b0, 3'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL single_end: {busy,sel,note}=%b occ=%0d, want 00000 0",
                     play_vec(), occupancy);
        end
    endtask

    task automatic test_back_to_back();
        logic [SEL_W-1:0] sels [7];
        logic [6:0]       pat;
        sels = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd0, 3'd0};
        pat  = 7'b1011100;
        req_val = 1'b1; req_num = 3'd1; req_dur = 16'd3;
        tick();
        req_num = 3'd3; req_dur = 16'd2;
        tick();
        checks++;
        if (play_vec() !== {1'b1, sels[0], pat[6]}) begin
            errors++;
            $display("FAIL b2b_cycle0: %b want %b", play_vec(), {1'b1, sels[0], pat[6]});
        end
        req_num = 3'd0; req_dur = 16'd2;
        tick();
        req_val = 1'b0;
        checks++;
        if (play_vec() !== {1'b1, sels[1], pat[5]}) begin
            errors++;
            $display("FAIL b2b_cycle1: %b want %b", play_vec(), {1'b1, sels[1], pat[5]});
        end
        for (int i = 2; i < 7; i++) begin
            tick();
            checks++;
            if (play_vec() !== {1'b1, sels[i], pat[6-i]}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: {busy,sel,note}=%b want %b",
                         i, play_vec(), {1'b1, sels[i], pat[6-i]});
            end
        end
        tick();
        checks++;
        if (play_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL b2b_end: %b want 00000", play_vec());
        end
    endtask

    task automatic test_fill();
        req_val = 1'b1; req_num = 3'd1; req_dur = 16'd10;
        tick();
        for (int k = 2; k <= 5; k++) begin
            req_num = SEL_W'(k); req_dur = 16'd1;
            tick();
        end
        checks++;
        if ({occupancy, req_rdy} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_full: occ=%0d rdy=%b want 4 0", occupancy, req_rdy);
        end
        req_num = 3'd6;
        tick();
        req_val = 1'b0;
        checks++;
        if ({occupancy, req_rdy} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_push_ignored: occ=%0d rdy=%b want 4 0", occupancy, req_rdy);
        end
        repeat (5) tick();
        checks++;
        if ({occupancy, req_rdy, busy, note_sel} !== {3'd4, 1'b0, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL fill_last_cycle: occ=%0d rdy=%b busy=%b sel=%0d want 4 0 1 1",
                     occupancy, req_rdy, busy, note_sel);
        end
        tick();
        checks++;
        if ({occupancy, req_rdy, note_sel} !== {3'd3, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL fill_after_pop: occ=%0d rdy=%b sel=%0d want 3 1 2",
                     occupancy, req_rdy, note_sel);
        end
        for (int k = 3; k <= 5; k++) begin
            tick();
            checks++;
            if ({busy, note_sel} !== {1'b1, SEL_W'(k)}) begin
                errors++;
                $display("FAIL fill_drain%0d: busy=%b sel=%0d want 1 %0d", k, busy, note_sel, k);
            end
        end
        tick();
        checks++;
        if ({busy, note_sel, occupancy} !== {1'b0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL fill_end: busy=%b sel=%0d occ=%0d want 0 0 0", busy, note_sel, occupancy);
        end
    endtask

    task automatic test_edge_cases();
        req_val = 1'b1; req_num = 3'd3; req_dur = 16'd0;
        tick();
        req_val = 1'b0;
        tick();
        checks++;
        if (play_vec() !== {1'b1, 3'd3, 1'b1}) begin
            errors++;
            $display("FAIL dur0_play: %b want 10111", play_vec());
        end
        tick();
        checks++;
        if (play_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL dur0_end: %b want 00000", play_vec());
        end

        note_periods = PERIODS_N7_ZERO;
        req_val = 1'b1; req_num = 3'd7; req_dur = 16'd2;
        tick();
        req_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (play_vec() !== {1'b1, 3'd7, 1'b0}) begin
                errors++;
                $display("FAIL period0_cycle%0d: %b want 11110", i, play_vec());
            end
        end
        tick();
        checks++;
        if (play_vec() !== 5'b00000) begin
            errors++;
            $display("FAIL period0_end: %b want 00000", play_vec());
        end
        note_periods = PERIODS_STD;
    endtask

    task automatic test_wrap();
        logic [SEL_W-1:0] seq [2*DEPTH];
        seq = '{3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd2, 3'd7, 3'd0};
        req_val = 1'b1; req_dur = 16'd1;
        for (int i = 0; i < 2*DEPTH; i++) begin
            req_num = seq[i];
            tick();
            if (i >= 1) begin
                checks++;
                if ({busy, note_sel} !== {1'b1, seq[i-1]}) begin
                    errors++;
                    $display("FAIL wrap_order%0d: busy=%b sel=%0d want 1 %0d",
                             i-1, busy, note_sel, seq[i-1]);
                end
            end
        end
        req_val = 1'b0;
        tick();
        checks++;
        if ({busy, note_sel} !== {1'b1, seq[2*DEPTH-1]}) begin
            errors++;
            $display("FAIL wrap_last: busy=%b sel=%0d want 1 %0d", busy, note_sel, seq[2*DEPTH-1]);
        end
        tick();
        checks++;
        if ({busy, occupancy} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL wrap_end: busy=%b occ=%0d want 0 0", busy, occupancy);
        end
    endtask

    task automatic test_reset_mid_note();
        req_val = 1'b1; req_num = 3'd1; req_dur = 16'd20;
        tick();
        for (int k = 2; k <= 4; k++) begin
            req_num = SEL_W'(k); req_dur = 16'd5;
            tick();
        end
        req_val = 1'b0;
        checks++;
        if ({occupancy, busy, note_sel} !== {3'd3, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL midrst_setup: occ=%0d busy=%b sel=%0d want 3 1 1",
                     occupancy, busy, note_sel);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_rdy, busy, note_sel, note, occupancy} !== {1'b1, 1'b0, 3'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midrst_async: rdy=%b busy=%b sel=%0d note=%b occ=%0d want 1 0 0 0 0",
                     req_rdy, busy, note_sel, note, occupancy);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({busy, note, occupancy} !== {1'b0, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL midrst_residual%0d: busy=%b note=%b occ=%0d want 0 0 0",
                         i, busy, note, occupancy);
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        req_val      = 1'b0;
        req_num      = '0;
        req_dur      = '0;
        note_periods = PERIODS_STD;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_edge_cases();
        test_wrap();
        test_reset_mid_note();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
